// File: rtl/maze_path_checker.sv
// maze_path_checker: streams a stored 17x17 maze to the solver, then walks the solver's
// direction stream from (0,0) and reports a pass/fail verdict with an error code and step count.
module maze_path_checker #(
    parameter int MAZE_WIDTH = 17,
    parameter int DIR_WIDTH  = 2,
    parameter int STEP_WIDTH = 9,
    parameter int TIMEOUT    = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  row_valid,
    input  logic [4:0]            row_idx,
    input  logic [MAZE_WIDTH-1:0] row_data,
    input  logic                  start,
    output logic                  maze_valid,
    output logic                  maze_bit,
    input  logic                  path_valid,
    input  logic [DIR_WIDTH-1:0]  path_dir,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [2:0]            err_code,
    output logic [STEP_WIDTH-1:0] step_cnt
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SEND   = 3'd1;
    localparam logic [2:0] WAIT   = 3'd2;
    localparam logic [2:0] WALK   = 3'd3;
    localparam logic [2:0] REPORT = 3'd4;
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [4:0] LAST = 5'(MAZE_WIDTH - 1);

    logic [MAZE_WIDTH-1:0] maze [MAZE_WIDTH];
    logic [2:0]            state;
    logic [4:0]            sr, sc, snr, snc, r, c, nr, nc;
    logic [CW-1:0]         wait_cnt;
    logic                  oob, at_goal;
    logic [2:0]            step_err;

    always_comb begin
        snc = sc == LAST ? 5'd0 : sc + 5'd1;
        snr = sc == LAST ? sr + 5'd1 : sr;
        oob = (path_dir == 2'd0 && c == LAST) || (path_dir == 2'd1 && r == LAST) ||
              (path_dir == 2'd2 && c == 5'd0) || (path_dir == 2'd3 && r == 5'd0);
        nr = path_dir == 2'd1 ? r + 5'd1 : path_dir == 2'd3 ? r - 5'd1 : r;
        nc = path_dir == 2'd0 ? c + 5'd1 : path_dir == 2'd2 ? c - 5'd1 : c;
        at_goal = r == LAST && c == LAST;
        // any beat arriving once the goal is reached is an overrun, whatever its direction
        step_err = at_goal ? 3'd5 : oob ? 3'd1 : !maze[nr][nc] ? 3'd2 : 3'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < MAZE_WIDTH; i++) maze[i] <= '0;
            state      <= IDLE;
            maze_valid <= 1'b0;
            maze_bit   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_code   <= 3'd0;
            step_cnt   <= '0;
            sr         <= 5'd0;
            sc         <= 5'd0;
            r          <= 5'd0;
            c          <= 5'd0;
            wait_cnt   <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (row_valid && row_idx <= LAST) maze[row_idx] <= row_data;
                if (start) begin
                    state      <= SEND;
                    busy       <= 1'b1;
                    maze_valid <= 1'b1;
                    // a row-0 write in the start cycle must already show up in bit 0
                    maze_bit   <= (row_valid && row_idx == 5'd0) ? row_data[0] : maze[0][0];
                    sr         <= 5'd0;
                    sc         <= 5'd0;
                    r          <= 5'd0;
                    c          <= 5'd0;
                    pass       <= 1'b0;
                    err_code   <= 3'd0;
                    step_cnt   <= '0;
                end
            end else if (state == SEND) begin
                if (sr == LAST && sc == LAST) begin
                    state      <= WAIT;
                    maze_valid <= 1'b0;
                    maze_bit   <= 1'b0;
                    wait_cnt   <= '0;
                end else begin
                    sr       <= snr;
                    sc       <= snc;
                    maze_bit <= maze[snr][snc];
                end
            end else if (state == WAIT || state == WALK) begin
                if (path_valid) begin
                    state    <= WALK;
                    step_cnt <= &step_cnt ? step_cnt : step_cnt + 1'b1;
                    if (err_code == 3'd0) begin
                        err_code <= step_err;
                        if (step_err == 3'd0) begin
                            r <= nr;
                            c <= nc;
                        end
                    end
                end else if (state == WALK) begin
                    state    <= REPORT;
                    done     <= 1'b1;
                    err_code <= (err_code == 3'd0 && !at_goal) ? 3'd3 : err_code;
                    pass     <= err_code == 3'd0 && at_goal;
                end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                    state    <= REPORT;
                    done     <= 1'b1;
                    err_code <= 3'd4;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end else begin
                state <= IDLE;
                busy  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_maze_path_checker.sv
// tb_maze_path_checker: directed runs of maze_path_checker; verdicts are queued when a path
// is driven and checked against the DUT when done pulses.
module tb_maze_path_checker;
    localparam int TIMEOUT = 4096;

    typedef struct {
        logic [2:0] err;
        logic       ps;
        logic [8:0] steps;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        row_valid = 1'b0;
    logic [4:0]  row_idx = 5'd0;
    logic [16:0] row_data = '0;
    logic        start = 1'b0;
    logic        maze_valid, maze_bit;
    logic        path_valid = 1'b0;
    logic [1:0]  path_dir = 2'd0;
    logic        busy, done, pass;
    logic [2:0]  err_code;
    logic [8:0]  step_cnt;

    int n_assert = 0;
    int n_fail = 0;
    logic [16:0] mz [17];
    logic [1:0]  pq[$];
    exp_t        sbq[$];

    maze_path_checker #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .row_valid(row_valid), .row_idx(row_idx),
        .row_data(row_data), .start(start), .maze_valid(maze_valid), .maze_bit(maze_bit),
        .path_valid(path_valid), .path_dir(path_dir), .busy(busy), .done(done),
        .pass(pass), .err_code(err_code), .step_cnt(step_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_row(input int i, input logic [16:0] d);
        row_valid = 1'b1;
        row_idx = 5'(i);
        row_data = d;
        tick();
        row_valid = 1'b0;
        mz[i] = d;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 17; i++) mz[i] = '0;
    endtask

    // start (optionally with a row-0 write in the same cycle) and check all 289 transmitted bits
    task automatic send(input string tag, input logic with_row0, input logic [16:0] d0,
                        input logic junk_path);
        int vcnt, bad;
        if (with_row0) begin
            row_valid = 1'b1;
            row_idx = 5'd0;
            row_data = d0;
            mz[0] = d0;
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        row_valid = 1'b0;
        path_valid = junk_path;
        path_dir = 2'd3;
        vcnt = 0;
        bad = 0;
        for (int k = 0; k < 289; k++) begin
            if (maze_valid === 1'b1) vcnt++;
            if (maze_bit !== mz[k / 17][k % 17]) bad++;
            tick();
        end
        path_valid = 1'b0;
        chk({tag, "_valid_cycles"}, vcnt, 289);
        chk({tag, "_bit_errors"}, bad, 0);
        chk({tag, "_valid_fall"}, maze_valid, 1'b0);
        chk({tag, "_busy"}, busy, 1'b1);
    endtask

    task automatic check_verdict(input string tag);
        exp_t e;
        chk({tag, "_done"}, done, 1'b1);
        if (sbq.size() == 0) begin
            chk({tag, "_scoreboard_empty"}, 1, 0);
        end else begin
            e = sbq.pop_front();
            chk({tag, "_err_code"}, err_code, e.err);
            chk({tag, "_pass"}, pass, e.ps);
            chk({tag, "_step_cnt"}, step_cnt, e.steps);
        end
        tick();
        chk({tag, "_done_pulse"}, done, 1'b0);
        chk({tag, "_busy_end"}, busy, 1'b0);
    endtask

    task automatic walk(input string tag, input logic [2:0] err, input logic ps,
                        input logic [8:0] steps);
        sbq.push_back('{err, ps, steps});
        foreach (pq[i]) begin
            path_valid = 1'b1;
            path_dir = pq[i];
            tick();
        end
        path_valid = 1'b0;
        tick();
        check_verdict(tag);
    endtask

    task automatic build_path(input int n);
        pq.delete();
        for (int i = 0; i < n; i++) pq.push_back(i < 16 ? 2'd1 : 2'd0);
    endtask

    initial begin
        int cnt;
        for (int i = 0; i < 17; i++) mz[i] = '0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_maze_valid", maze_valid, 1'b0);
        chk("rst_maze_bit", maze_bit, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_pass", pass, 1'b0);
        chk("rst_err", err_code, 3'd0);
        chk("rst_steps", step_cnt, 9'd0);

        // row 0 open, rest walls; no path at all -> timeout
        load_row(0, 17'h1FFFF);
        send("row0", 1'b0, '0, 1'b0);
        sbq.push_back('{3'd4, 1'b0, 9'd0});
        cnt = 0;
        while (done !== 1'b1 && cnt < TIMEOUT + 20) begin
            tick();
            cnt++;
        end
        chk("timeout_cycles", cnt, TIMEOUT);
        check_verdict("timeout");

        // all open, row 0 written in the start cycle, path_valid junk during SEND
        for (int i = 1; i < 17; i++) load_row(i, 17'h1FFFF);
        load_row(0, 17'h0);
        send("open", 1'b1, 17'h1FFFF, 1'b1);
        build_path(32);
        walk("pass32", 3'd0, 1'b1, 9'd32);

        // wall at (0,1), first beat RIGHT hits it
        load_row(0, 17'h1FFFD);
        send("wall", 1'b0, '0, 1'b0);
        pq.delete();
        pq.push_back(2'd0);
        for (int i = 0; i < 16; i++) pq.push_back(2'd1);
        for (int i = 0; i < 15; i++) pq.push_back(2'd0);
        walk("wall_hit", 3'd2, 1'b0, 9'd32);

        load_row(0, 17'h1FFFF);
        send("oob", 1'b0, '0, 1'b0);
        pq.delete();
        pq.push_back(2'd3);
        walk("oob_up", 3'd1, 1'b0, 9'd1);

        send("short", 1'b0, '0, 1'b0);
        build_path(31);
        walk("short31", 3'd3, 1'b0, 9'd31);

        send("over", 1'b0, '0, 1'b0);
        build_path(32);
        pq.push_back(2'd0);
        walk("overrun", 3'd5, 1'b0, 9'd33);

        // reset in cycle 100 of SEND aborts the run and clears the maze
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 99; i++) tick();
        rst_n = 1'b0;
        tick();
        chk("abort_maze_valid", maze_valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 17; i++) mz[i] = '0;
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            if (done === 1'b1 || maze_valid === 1'b1) cnt++;
            tick();
        end
        chk("abort_quiet", cnt, 0);
        send("walls", 1'b0, '0, 1'b0);
        do_reset();
        chk("final_busy", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
